// File: rtl/tmds_encoder_bank.sv
// tmds_encoder_bank: N-channel TMDS 8b/10b encoder bank in the pixel-clock domain.
// Two registered stages: per-channel q_m transition minimisation, then DC-balance / control coding.
// Optional feature macro: HDMI_GUARD_BAND_EN. When defined, a 10-deep input delay line is inserted and
// the live de_i acts as a look-ahead so that HDMI video preamble and guard band can be placed in the
// blanking cycles that precede each active-video period.
module tmds_encoder_bank #(
  parameter int NB_CHAN = 3
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    de_i,
  input  logic [2*NB_CHAN-1:0]    ctrl_i,
  input  logic [8*NB_CHAN-1:0]    data_i,
  output logic [10*NB_CHAN-1:0]   tmds_o,
  output logic                    de_o
);

  // Stream entering stage 1 (live inputs, or the delayed stream with preamble overrides applied)
  logic                  w_s0_de;
  logic [2*NB_CHAN-1:0]  w_s0_ctrl;
  logic [8*NB_CHAN-1:0]  w_s0_data;
  logic                  w_s0_guard;

`ifdef HDMI_GUARD_BAND_EN
  // r_dl_de[0] is the newest sample, r_dl_de[9] the oldest (the one being encoded next)
  logic [9:0]            r_dl_de;
  logic [2*NB_CHAN-1:0]  r_dl_ctrl [10];
  logic [8*NB_CHAN-1:0]  r_dl_data [10];
  // w_future[k] = de of the delayed stream k cycles after the oldest entry
  logic [10:1]           w_future;
  logic [3:0]            w_k;
  logic                  w_pre;

  // 10-deep delay line for de, ctrl and data
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_dl_de <= '0;
      for (int i = 0; i < 10; i++) begin
        r_dl_ctrl[i] <= '0;
        r_dl_data[i] <= '0;
      end
    end else begin
      r_dl_de      <= {r_dl_de[8:0], de_i};
      r_dl_ctrl[0] <= ctrl_i;
      r_dl_data[0] <= data_i;
      for (int i = 1; i < 10; i++) begin
        r_dl_ctrl[i] <= r_dl_ctrl[i-1];
        r_dl_data[i] <= r_dl_data[i-1];
      end
    end
  end

  for (genvar gi = 1; gi < 10; gi++) begin : g_future
    assign w_future[gi] = r_dl_de[9-gi];
  end
  assign w_future[10] = de_i;

  // Distance to the nearest upcoming de=1 in the look-ahead window (0 = none within 10)
  always_comb begin
    w_k = 4'd0;
    for (int k = 10; k >= 1; k--) begin
      if (w_future[k]) w_k = 4'(k);
    end
  end

  assign w_pre      = !r_dl_de[9] && (w_k >= 4'd3);
  assign w_s0_guard = !r_dl_de[9] && (w_k != 4'd0) && (w_k <= 4'd2);
  assign w_s0_de    = r_dl_de[9];
  assign w_s0_data  = r_dl_data[9];

  // Video preamble: ch1 ctrl = 01, ch2 ctrl = 00; ch0 keeps its sync pair
  always_comb begin
    w_s0_ctrl = r_dl_ctrl[9];
    if (w_pre) begin
      w_s0_ctrl[3:2] = 2'b01;
      w_s0_ctrl[5:4] = 2'b00;
    end
  end
`else
  assign w_s0_de    = de_i;
  assign w_s0_ctrl  = ctrl_i;
  assign w_s0_data  = data_i;
  assign w_s0_guard = 1'b0;
`endif

  logic                  r_s1_de;
  logic                  r_s1_guard;
  logic [2*NB_CHAN-1:0]  r_s1_ctrl;
  logic                  r_de_o;

  // Stage-1 and output registers shared by all channels
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_s1_de    <= 1'b0;
      r_s1_guard <= 1'b0;
      r_s1_ctrl  <= '0;
      r_de_o     <= 1'b0;
    end else begin
      r_s1_de    <= w_s0_de;
      r_s1_guard <= w_s0_guard;
      r_s1_ctrl  <= w_s0_ctrl;
      r_de_o     <= r_s1_de;
    end
  end

  assign de_o = r_de_o;

  for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_chan
    // Guard-band symbol differs on ch1; only ch0..ch2 are ever overridden
    localparam logic [9:0] GUARD_SYM = (gi == 1) ? 10'h133 : 10'h2CC;
    localparam bit         HAS_GUARD = (gi < 3);

    logic [7:0]        w_d;
    logic [3:0]        w_n1;
    logic              w_xnor;
    logic [8:0]        w_qm;
    logic [8:0]        r_qm;
    logic [3:0]        w_ones;
    logic signed [5:0] w_diff6;
    logic signed [4:0] w_diff;
    logic [1:0]        w_c;
    logic [9:0]        w_sym;
    logic signed [4:0] w_cnt_next;
    logic [9:0]        r_sym;
    logic signed [4:0] r_cnt;

    assign w_d    = w_s0_data[8*gi +: 8];
    assign w_n1   = 4'($countones(w_d));
    assign w_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !w_d[0]);

    // A chain of i XNORs equals the prefix parity inverted on odd bit positions
    assign w_qm[0] = w_d[0];
    for (genvar gj = 1; gj < 8; gj++) begin : g_qm
      assign w_qm[gj] = (^w_d[gj:0]) ^ ((gj % 2 == 1) ? w_xnor : 1'b0);
    end
    assign w_qm[8] = !w_xnor;

    // Stage 1: hold the transition-minimised word
    always_ff @(posedge clk_pix) begin
      if (!rst_n) r_qm <= '0;
      else        r_qm <= w_qm;
    end

    assign w_ones  = 4'($countones(r_qm[7:0]));
    assign w_diff6 = $signed({1'b0, w_ones, 1'b0}) - 6'sd8;   // N1 - N0
    assign w_diff  = w_diff6[4:0];
    assign w_c     = r_s1_ctrl[2*gi +: 2];

    // Stage 2 next state: DC-balance coding for video, fixed symbols for blanking
    always_comb begin
      w_sym      = 10'h354;
      w_cnt_next = r_cnt;
      if (!r_s1_de) begin
        w_cnt_next = 5'sd0;
        if (HAS_GUARD && r_s1_guard) begin
          w_sym = GUARD_SYM;
        end else begin
          case (w_c)
            2'b00:   w_sym = 10'h354;
            2'b01:   w_sym = 10'h0AB;
            2'b10:   w_sym = 10'h154;
            default: w_sym = 10'h2AB;
          endcase
        end
      end else if ((r_cnt == 5'sd0) || (w_ones == 4'd4)) begin
        w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
        w_cnt_next = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if (((r_cnt > 5'sd0) && (w_ones > 4'd4)) || ((r_cnt < 5'sd0) && (w_ones < 4'd4))) begin
        w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt_next = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
      end else begin
        w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt_next = r_cnt - (r_qm[8] ? 5'sd0 : 5'sd2) + w_diff;
      end
    end

    // Stage 2: output symbol and running disparity
    always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
        r_sym <= 10'h354;
        r_cnt <= 5'sd0;
      end else begin
        r_sym <= w_sym;
        r_cnt <= w_cnt_next;
      end
    end

    assign tmds_o[10*gi +: 10] = r_sym;
  end

endmodule

// File: tb/tb_tmds_encoder_bank.sv
// Bench for tmds_encoder_bank (NB_CHAN=4): reference model over the full input history plus
// hand-computed literal expectations for reset, control symbols, disparity and preamble/guard band.
module tb_tmds_encoder_bank;
  localparam int NB = 4;
`ifdef HDMI_GUARD_BAND_EN
  localparam int L  = 12;
  localparam bit GB = 1'b1;
`else
  localparam int L  = 2;
  localparam bit GB = 1'b0;
`endif
  localparam int MAXE = 16384;

  logic              clk_pix;
  logic              rst_n;
  logic              de_i;
  logic [2*NB-1:0]   ctrl_i;
  logic [8*NB-1:0]   data_i;
  logic [10*NB-1:0]  tmds_o;
  logic              de_o;

  tmds_encoder_bank #(.NB_CHAN(NB)) dut (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .de_i    (de_i),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .tmds_o  (tmds_o),
    .de_o    (de_o)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Effective input history, one entry per clock edge
  bit              h_rst  [MAXE];
  bit              h_de   [MAXE];
  logic [2*NB-1:0] h_ctrl [MAXE];
  logic [8*NB-1:0] h_data [MAXE];
  int              edge_n = 0;

  int n_vec = 0;
  int n_err = 0;
  int m_cnt [NB];
  int bal   [NB];

  typedef struct {
    int         t;
    int         lane;
    logic [9:0] v;
    string      nm;
  } pin_t;
  pin_t pins [$];

  // Spec-level 8b/10b encoder: XOR/XNOR chain then DC-balance rules
  function automatic void enc(input logic [7:0] d, input int cin, output logic [9:0] sym, output int cout);
    int n1, o, z;
    bit use_xnor;
    logic [8:0] q;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !use_xnor;
    o = $countones(q[7:0]);
    z = 8 - o;
    if (cin == 0 || o == z) begin
      sym  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cout = cin + (q[8] ? (o - z) : (z - o));
    end else if ((cin > 0 && o > z) || (cin < 0 && z > o)) begin
      sym  = {1'b1, q[8], ~q[7:0]};
      cout = cin + (q[8] ? 2 : 0) + (z - o);
    end else begin
      sym  = {1'b0, q[8], q[7:0]};
      cout = cin - (q[8] ? 0 : 2) + (o - z);
    end
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] tbl [4];
    tbl[0] = 10'b1101010100;
    tbl[1] = 10'b0010101011;
    tbl[2] = 10'b0101010100;
    tbl[3] = 10'b1010101011;
    return tbl[c];
  endfunction

  // Record what the DUT sampled; a reset edge wipes every item still inside the pipeline
  always @(posedge clk_pix) begin
    h_rst[edge_n]  = !rst_n;
    h_de[edge_n]   = de_i;
    h_ctrl[edge_n] = ctrl_i;
    h_data[edge_n] = data_i;
    if (!rst_n) begin
      for (int j = edge_n - (L - 1); j <= edge_n; j++) begin
        if (j >= 0) begin
          h_de[j]   = 1'b0;
          h_ctrl[j] = '0;
          h_data[j] = '0;
        end
      end
    end
    edge_n++;
  end

  // Single compare process, away from the active edge
  always @(negedge clk_pix) begin
    int t, s, k, nc;
    logic [9:0] exp_sym, got;
    logic [1:0] c;
    if (edge_n >= 1) begin
      t = edge_n - 1;
      if (h_rst[t]) begin
        for (int ch = 0; ch < NB; ch++) begin
          n_vec++;
          if (tmds_o[10*ch +: 10] !== 10'h354) begin
            n_err++;
            $display("FAIL reset_sym t=%0d lane%0d got %h want 354", t, ch, tmds_o[10*ch +: 10]);
          end
        end
        n_vec++;
        if (de_o !== 1'b0) begin
          n_err++;
          $display("FAIL reset_de t=%0d got %b want 0", t, de_o);
        end
      end
      s = t - (L - 1);
      if (s >= 0) begin
        k = 0;
        if (GB && !h_de[s]) begin
          for (int j = 1; j <= 10; j++) if (k == 0 && h_de[s+j]) k = j;
        end
        n_vec++;
        if (de_o !== h_de[s]) begin
          n_err++;
          $display("FAIL model_de t=%0d got %b want %b", t, de_o, h_de[s]);
        end
        for (int ch = 0; ch < NB; ch++) begin
          if (h_de[s]) begin
            enc(h_data[s][8*ch +: 8], m_cnt[ch], exp_sym, nc);
            m_cnt[ch] = nc;
          end else begin
            m_cnt[ch] = 0;
            c = h_ctrl[s][2*ch +: 2];
            if (k >= 3 && ch == 1) c = 2'b01;
            if (k >= 3 && ch == 2) c = 2'b00;
            exp_sym = ctrl_sym(c);
            if (k >= 1 && k <= 2 && ch < 3) exp_sym = (ch == 1) ? 10'h133 : 10'h2CC;
          end
          got = tmds_o[10*ch +: 10];
          n_vec++;
          if (got !== exp_sym) begin
            n_err++;
            $display("FAIL model_sym t=%0d lane%0d got %h want %h", t, ch, got, exp_sym);
          end
          // Running disparity of emitted video symbols must stay within +-10
          if (de_o === 1'b1) begin
            bal[ch] += 2 * $countones(got) - 10;
            n_vec++;
            if (bal[ch] > 10 || bal[ch] < -10) begin
              n_err++;
              $display("FAIL balance t=%0d lane%0d got %0d want |x|<=10", t, ch, bal[ch]);
            end
          end else begin
            bal[ch] = 0;
          end
        end
      end
      for (int i = 0; i < pins.size(); i++) begin
        if (pins[i].t == t) begin
          got = tmds_o[10*pins[i].lane +: 10];
          n_vec++;
          if (got !== pins[i].v) begin
            n_err++;
            $display("FAIL %s t=%0d lane%0d got %h want %h", pins[i].nm, t, pins[i].lane, got, pins[i].v);
          end else begin
            $display("check %s t=%0d lane%0d got %h ok", pins[i].nm, t, pins[i].lane, got);
          end
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit de, input logic [2*NB-1:0] c,
                       input logic [8*NB-1:0] d, output int idx);
    @(negedge clk_pix);
    rst_n  = !rst;
    de_i   = de;
    ctrl_i = c;
    data_i = d;
    idx    = edge_n;
  endtask

  task automatic pin(input int item, input int lane, input logic [9:0] v, input string nm);
    pin_t p;
    p.t = item + L - 1;
    p.lane = lane;
    p.v = v;
    p.nm = nm;
    pins.push_back(p);
  endtask

  function automatic logic [2*NB-1:0] rc();
    return (2*NB)'($urandom);
  endfunction

  function automatic logic [8*NB-1:0] rd();
    return (8*NB)'($urandom);
  endfunction

  initial begin
    int idx, a;
    bit cur_de;
    logic [1:0] cseq [4];
    for (int ch = 0; ch < NB; ch++) begin
      m_cnt[ch] = 0;
      bal[ch] = 0;
    end
    rst_n = 1'b0; de_i = 1'b0; ctrl_i = '0; data_i = '0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) drive(1'b1, 1'(($urandom)), rc(), rd(), idx);

    // First symbol after release, then 0x00 disparity sequence on ch0
    drive(1'b0, 1'b1, rc(), {rd()} & 32'hFFFF_FF00, a);
    pin(a - 1, 0, GB ? 10'h2CC : 10'h354, "pre_first");
    pin(a, 0, 10'h100, "first_sym_cnt0");
    drive(1'b0, 1'b1, rc(), {rd()} & 32'hFFFF_FF00, a);
    pin(a, 0, 10'h3FF, "disp_cnt_m8");
    drive(1'b0, 1'b1, rc(), {rd()} & 32'hFFFF_FF00, a);
    pin(a, 0, 10'h100, "disp_cnt_p2");

    // One-cycle blanking restarts disparity
    drive(1'b0, 1'b0, rc() & 8'hFC, rd(), idx);
    drive(1'b0, 1'b1, rc(), {rd()} & 32'hFFFF_FF00, a);
    pin(a, 0, 10'h100, "disp_restart");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, rc(), rd(), idx);

    // Control symbols on ch0, followed by a long blanking tail
    cseq[0] = 2'b00; cseq[1] = 2'b01; cseq[2] = 2'b10; cseq[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, {rc()} & 8'hFC | {6'b0, cseq[i]}, rd(), a);
      pin(a, 0, ctrl_sym(cseq[i]), "ctrl_sym");
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, rc(), rd(), idx);

    // Video, 20-cycle gap (ch0=01, ch1=10, ch2=11, ch3=11), video
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, rc(), rd(), idx);
    for (int g = 1; g <= 20; g++) begin
      drive(1'b0, 1'b0, 8'b11_11_10_01, rd(), a);
      if (g == 10) pin(a, 1, 10'h154, "gap_before_pre");
      if (g >= 11 && g <= 18) begin
        pin(a, 1, GB ? 10'h0AB : 10'h154, "preamble_ch1");
        pin(a, 2, GB ? 10'h354 : 10'h2AB, "preamble_ch2");
      end
      if (g >= 19) begin
        pin(a, 0, GB ? 10'h2CC : 10'h0AB, "guard_ch0");
        pin(a, 1, GB ? 10'h133 : 10'h154, "guard_ch1");
        pin(a, 2, GB ? 10'h2CC : 10'h2AB, "guard_ch2");
        pin(a, 3, 10'h2AB, "guard_ch3_untouched");
      end
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, rc(), rd(), idx);

    // 5-cycle gap: 3 preamble + 2 guard
    for (int g = 1; g <= 5; g++) begin
      drive(1'b0, 1'b0, 8'b11_11_10_01, rd(), a);
      if (g <= 3) pin(a, 1, GB ? 10'h0AB : 10'h154, "short_pre_ch1");
      else        pin(a, 1, GB ? 10'h133 : 10'h154, "short_guard_ch1");
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, rc(), rd(), idx);

    // Mid-frame reset for one cycle
    drive(1'b1, 1'b1, rc(), rd(), idx);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, rc(), rd(), idx);

    // Long random stream, independent data per channel
    cur_de = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 11) == 0) cur_de = !cur_de;
      drive(1'b0, cur_de, rc(), rd(), idx);
    end

    // Flush the pipeline
    for (int i = 0; i < L + 4; i++) drive(1'b0, 1'b0, '0, '0, idx);
    @(negedge clk_pix);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
